// File: rtl/seq_alu.sv
// seq_alu: parametrised execute-stage ALU with a valid/ready handshake.
// Single-cycle ops complete at the accept edge; mul/div iterate one bit per cycle.
module seq_alu #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       opcode,
    input  logic [3:0]       fcode,
    input  logic [WIDTH-1:0] input1,
    input  logic [WIDTH-1:0] input2,
    output logic             out_valid,
    output logic [WIDTH-1:0] out,
    output logic [WIDTH-1:0] out_hi,
    output logic             carryFlag,
    output logic             zeroflag,
    output logic             signFlag,
    output logic             overflowFlag
);

    localparam int unsigned CW = $clog2(WIDTH);
    localparam logic [2:0] OP_R = 3'b000;
    localparam logic [2:0] OP_I = 3'b001;
    localparam logic [2:0] OP_B = 3'b101;

    typedef enum logic {IDLE, ITER} state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              mul_q, mul_d;
    logic [WIDTH-1:0]  opnd_q, opnd_d;
    logic [WIDTH-1:0]  hi_q, hi_d;
    logic [WIDTH-1:0]  lo_q, lo_d;
    logic [WIDTH-1:0]  out_q, out_d;
    logic [WIDTH-1:0]  out_hi_q, out_hi_d;
    logic              out_valid_q, out_valid_d;
    logic              c_q, c_d, z_q, z_d, s_q, s_d, v_q, v_d;

    logic [WIDTH-1:0]  sc_out;
    logic              sc_c, sc_v, sc_z, sc_s;
    logic              legal, branch, is_mul, is_div, shamt_big;
    logic [WIDTH:0]    sum, diff;
    logic [CW-1:0]     sh;

    assign in_ready = (state_q == IDLE) && !rst;

    // Decode and evaluate the single-cycle operations.
    always_comb begin
        sc_out    = '0;
        sc_c      = 1'b0;
        sc_v      = 1'b0;
        legal     = 1'b0;
        branch    = 1'b0;
        is_mul    = 1'b0;
        is_div    = 1'b0;
        sum       = {1'b0, input1} + {1'b0, input2};
        diff      = {1'b0, input1} - {1'b0, input2};
        shamt_big = input2 >= WIDTH'(WIDTH);
        sh        = input2[CW-1:0];
        case (opcode)
            OP_R: begin
                legal = 1'b1;
                case (fcode)
                    4'b0000: sc_out = input1 ^ input2;
                    4'b0001: sc_out = input1 & input2;
                    4'b0010: sc_out = WIDTH'(0) - input2;
                    4'b0011: begin
                        sc_out = sum[WIDTH-1:0];
                        sc_c   = sum[WIDTH];
                        sc_v   = (input1[WIDTH-1] == input2[WIDTH-1])
                                 && (sum[WIDTH-1] != input1[WIDTH-1]);
                    end
                    4'b1010: begin
                        sc_out = diff[WIDTH-1:0];
                        sc_c   = !diff[WIDTH];
                        sc_v   = (input1[WIDTH-1] != input2[WIDTH-1])
                                 && (diff[WIDTH-1] != input1[WIDTH-1]);
                    end
                    4'b0100, 4'b0110: sc_out = shamt_big ? '0 : input1 << sh;
                    4'b0101, 4'b0111: sc_out = shamt_big ? '0 : input1 >> sh;
                    4'b1000, 4'b1001: sc_out = shamt_big ? {WIDTH{input1[WIDTH-1]}}
                                                         : WIDTH'($signed(input1) >>> sh);
                    4'b1011: is_mul = 1'b1;
                    4'b1100: is_div = 1'b1;
                    default: legal = 1'b0;
                endcase
            end
            OP_I: begin
                legal = 1'b1;
                case (fcode)
                    4'b0000: sc_out = WIDTH'(0) - input2;
                    4'b0001: begin
                        sc_out = sum[WIDTH-1:0];
                        sc_c   = sum[WIDTH];
                        sc_v   = (input1[WIDTH-1] == input2[WIDTH-1])
                                 && (sum[WIDTH-1] != input1[WIDTH-1]);
                    end
                    default: legal = 1'b0;
                endcase
            end
            OP_B: branch = (fcode <= 4'd2);
            default: legal = 1'b0;
        endcase
        sc_z = branch ? (input1 == '0) : (legal && (sc_out == '0));
        sc_s = branch ? input1[WIDTH-1] : sc_out[WIDTH-1];
    end

    logic [WIDTH:0]   mul_sum, div_sh;
    logic [WIDTH-1:0] div_sub;
    logic             div_ge;

    // Next-state: issue in IDLE, one shift-add or restoring-divide step per ITER cycle.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        mul_d       = mul_q;
        opnd_d      = opnd_q;
        hi_d        = hi_q;
        lo_d        = lo_q;
        out_d       = out_q;
        out_hi_d    = out_hi_q;
        out_valid_d = 1'b0;
        c_d         = c_q;
        z_d         = z_q;
        s_d         = s_q;
        v_d         = v_q;
        mul_sum     = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : '0);
        div_sh      = {hi_q, lo_q[WIDTH-1]};
        div_ge      = div_sh >= {1'b0, opnd_q};
        div_sub     = div_sh[WIDTH-1:0] - opnd_q;
        case (state_q)
            IDLE: begin
                if (in_valid && in_ready) begin
                    if (is_mul || is_div) begin
                        state_d = ITER;
                        cnt_d   = CW'(WIDTH - 1);
                        mul_d   = is_mul;
                        opnd_d  = is_mul ? input1 : input2;
                        lo_d    = is_mul ? input2 : input1;
                        hi_d    = '0;
                    end else begin
                        out_d       = sc_out;
                        out_hi_d    = '0;
                        c_d         = sc_c;
                        z_d         = sc_z;
                        s_d         = sc_s;
                        v_d         = sc_v;
                        out_valid_d = 1'b1;
                    end
                end
            end
            ITER: begin
                if (mul_q) begin
                    hi_d = mul_sum[WIDTH:1];
                    lo_d = {mul_sum[0], lo_q[WIDTH-1:1]};
                end else begin
                    hi_d = div_ge ? div_sub : div_sh[WIDTH-1:0];
                    lo_d = {lo_q[WIDTH-2:0], div_ge};
                end
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == '0) begin
                    state_d     = IDLE;
                    out_d       = lo_d;
                    out_hi_d    = hi_d;
                    c_d         = 1'b0;
                    z_d         = (lo_d == '0);
                    s_d         = lo_d[WIDTH-1];
                    v_d         = mul_q ? (hi_d != '0) : (opnd_q == '0);
                    out_valid_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            mul_q       <= 1'b0;
            opnd_q      <= '0;
            hi_q        <= '0;
            lo_q        <= '0;
            out_q       <= '0;
            out_hi_q    <= '0;
            out_valid_q <= 1'b0;
            c_q         <= 1'b0;
            z_q         <= 1'b0;
            s_q         <= 1'b0;
            v_q         <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            mul_q       <= mul_d;
            opnd_q      <= opnd_d;
            hi_q        <= hi_d;
            lo_q        <= lo_d;
            out_q       <= out_d;
            out_hi_q    <= out_hi_d;
            out_valid_q <= out_valid_d;
            c_q         <= c_d;
            z_q         <= z_d;
            s_q         <= s_d;
            v_q         <= v_d;
        end
    end

    assign out_valid    = out_valid_q;
    assign out          = out_q;
    assign out_hi       = out_hi_q;
    assign carryFlag    = c_q;
    assign zeroflag     = z_q;
    assign signFlag     = s_q;
    assign overflowFlag = v_q;

endmodule

// File: tb/tb_seq_alu.sv
// Directed self-checking bench for seq_alu at WIDTH=32.
// Flags are compared packed as {carry, zero, sign, overflow}.
module tb_seq_alu;

    localparam int unsigned W = 32;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [2:0]   opcode;
    logic [3:0]   fcode;
    logic [W-1:0] input1, input2;
    logic         out_valid;
    logic [W-1:0] out, out_hi;
    logic         carryFlag, zeroflag, signFlag, overflowFlag;

    int n_total = 0;
    int n_bad   = 0;

    seq_alu #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .opcode(opcode), .fcode(fcode), .input1(input1), .input2(input2),
        .out_valid(out_valid), .out(out), .out_hi(out_hi),
        .carryFlag(carryFlag), .zeroflag(zeroflag), .signFlag(signFlag),
        .overflowFlag(overflowFlag)
    );

    always #5 clk = ~clk;

    function automatic logic [3:0] flags();
        return {carryFlag, zeroflag, signFlag, overflowFlag};
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic [2:0] op, input logic [3:0] fc,
                         input logic [W-1:0] a, input logic [W-1:0] b);
        opcode = op; fcode = fc; input1 = a; input2 = b; in_valid = 1'b1;
    endtask

    // Issue at the next negedge; result is visible just after the accept edge.
    task automatic single(input string tag, input logic [2:0] op, input logic [3:0] fc,
                          input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] e_out, input logic [3:0] e_fl);
        @(negedge clk);
        drive(op, fc, a, b);
        @(posedge clk); #1;
        check({tag, "_valid"}, 64'(out_valid), 64'd1);
        check({tag, "_out"}, 64'(out), 64'(e_out));
        check({tag, "_hi"}, 64'(out_hi), 64'd0);
        check({tag, "_flags"}, 64'(flags()), 64'(e_fl));
    endtask

    task automatic multi(input string tag, input logic [3:0] fc,
                         input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] e_out, input logic [W-1:0] e_hi,
                         input logic [3:0] e_fl);
        int lat;
        int ready_hi;
        lat = 0;
        ready_hi = 0;
        @(negedge clk);
        drive(3'b000, fc, a, b);
        @(posedge clk); #1;
        if (in_ready) ready_hi++;
        for (int cyc = 1; cyc <= 64; cyc++) begin
            @(negedge clk);
            if (cyc == 5) drive(3'b000, 4'b0011, 32'd3, 32'd4);
            else in_valid = 1'b0;
            @(posedge clk); #1;
            if (out_valid) begin
                lat = cyc;
                break;
            end
            if (in_ready) ready_hi++;
        end
        check({tag, "_latency"}, 64'(lat), 64'd32);
        check({tag, "_ready_low"}, 64'(ready_hi), 64'd0);
        check({tag, "_ready_after"}, 64'(in_ready), 64'd1);
        check({tag, "_out"}, 64'(out), 64'(e_out));
        check({tag, "_hi"}, 64'(out_hi), 64'(e_hi));
        check({tag, "_flags"}, 64'(flags()), 64'(e_fl));
        @(negedge clk);
        @(posedge clk); #1;
        check({tag, "_pulse"}, 64'(out_valid), 64'd0);
        check({tag, "_hold"}, 64'(out), 64'(e_out));
    endtask

    logic [2:0]   t_op [10];
    logic [3:0]   t_fc [10];
    logic [W-1:0] t_a  [10], t_b [10], t_out [10];
    logic [3:0]   t_fl [10];

    task automatic set_vec(input int i, input logic [2:0] op, input logic [3:0] fc,
                           input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic [W-1:0] e, input logic [3:0] fl);
        t_op[i] = op; t_fc[i] = fc; t_a[i] = a; t_b[i] = b; t_out[i] = e; t_fl[i] = fl;
    endtask

    initial begin
        rst = 1'b1;
        in_valid = 1'b0;
        opcode = '0; fcode = '0; input1 = '0; input2 = '0;

        @(posedge clk); @(posedge clk); #1;
        check("rst_ready", 64'(in_ready), 64'd0);
        check("rst_valid", 64'(out_valid), 64'd0);
        check("rst_out", 64'({out, out_hi}), 64'd0);
        check("rst_flags", 64'(flags()), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_ready_after", 64'(in_ready), 64'd1);

        single("add_carry", 3'b000, 4'b0011, 32'hFFFF_FFFF, 32'h1, 32'h0, 4'b1100);
        single("add_ovf", 3'b000, 4'b0011, 32'h7FFF_FFFF, 32'h1, 32'h8000_0000, 4'b0011);
        single("sub", 3'b000, 4'b1010, 32'd5, 32'd7, 32'hFFFF_FFFE, 4'b0010);
        single("shra40", 3'b000, 4'b1000, 32'h8000_0000, 32'd40, 32'hFFFF_FFFF, 4'b0010);
        single("shll32", 3'b000, 4'b0100, 32'h1, 32'd32, 32'h0, 4'b0100);
        @(negedge clk);
        in_valid = 1'b0;

        multi("mul", 4'b1011, 32'h0001_0000, 32'h0001_0000, 32'h0, 32'h1, 4'b0101);
        multi("divu", 4'b1100, 32'd100, 32'd7, 32'd14, 32'd2, 4'b0000);
        multi("div0", 4'b1100, 32'd5, 32'd0, 32'hFFFF_FFFF, 32'd5, 4'b0011);

        // Reset sampled at iteration 10 of a multiply aborts it.
        begin
            int seen;
            seen = 0;
            @(negedge clk);
            drive(3'b000, 4'b1011, 32'd123, 32'd456);
            @(posedge clk);
            for (int k = 1; k <= 10; k++) begin
                @(negedge clk);
                in_valid = 1'b0;
                if (k == 10) rst = 1'b1;
                @(posedge clk); #1;
                if (out_valid) seen++;
            end
            check("abort_valid", 64'(out_valid), 64'd0);
            check("abort_out", 64'({out, out_hi}), 64'd0);
            check("abort_flags", 64'(flags()), 64'd0);
            check("abort_ready_rst", 64'(in_ready), 64'd0);
            @(negedge clk);
            rst = 1'b0;
            #1;
            check("abort_ready", 64'(in_ready), 64'd1);
            for (int k = 0; k < 40; k++) begin
                @(posedge clk); #1;
                if (out_valid) seen++;
            end
            check("abort_no_valid", 64'(seen), 64'd0);
            single("add_after_abort", 3'b000, 4'b0011, 32'd3, 32'd4, 32'd7, 4'b0000);
        end

        set_vec(0, 3'b000, 4'b0000, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'hFF00_FF00, 4'b0010);
        set_vec(1, 3'b000, 4'b0001, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'h00F0_00F0, 4'b0000);
        set_vec(2, 3'b000, 4'b0010, 32'h0, 32'h1, 32'hFFFF_FFFF, 4'b0010);
        set_vec(3, 3'b001, 4'b0001, 32'd10, 32'hFFFF_FFFE, 32'd8, 4'b1000);
        set_vec(4, 3'b101, 4'b0000, 32'h0, 32'h5, 32'h0, 4'b0100);
        set_vec(5, 3'b101, 4'b0010, 32'h8000_0000, 32'h0, 32'h0, 4'b0010);
        set_vec(6, 3'b111, 4'b0011, 32'h7, 32'h9, 32'h0, 4'b0000);
        set_vec(7, 3'b001, 4'b0000, 32'h0, 32'd5, 32'hFFFF_FFFB, 4'b0010);
        set_vec(8, 3'b000, 4'b0101, 32'h8000_0000, 32'd4, 32'h0800_0000, 4'b0000);
        set_vec(9, 3'b000, 4'b1111, 32'h1, 32'h1, 32'h0, 4'b0000);
        begin
            int pulses;
            pulses = 0;
            for (int i = 0; i < 10; i++) begin
                @(negedge clk);
                drive(t_op[i], t_fc[i], t_a[i], t_b[i]);
                @(posedge clk); #1;
                if (out_valid) pulses++;
                check($sformatf("b2b%0d_out", i), 64'(out), 64'(t_out[i]));
                check($sformatf("b2b%0d_flags", i), 64'(flags()), 64'(t_fl[i]));
            end
            check("b2b_pulses", 64'(pulses), 64'd10);
        end
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk); #1;
        check("idle_valid", 64'(out_valid), 64'd0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/seq_alu.md
# seq_alu

Parametrised, pipelined-handshake successor to the KGP RISC execute-stage ALU. Keeps the existing opcode/fcode encoding and flag set. Adds a WIDTH parameter, subtract, a signed-overflow flag, and iterative unsigned multiply and divide behind a valid/ready handshake. Single-cycle ops sustain one result per clock; multiply and divide stall the issue side for WIDTH cycles.

## Interface
- WIDTH, 32: operand/result width; must be ≥ 4 and a power of two.
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operation request.
- in_ready  out  1  block can accept; high only when state is IDLE and rst low.
- opcode  in  3  instruction class.
- fcode  in  4  function code.
- input1  in  WIDTH  operand A.
- input2  in  WIDTH  operand B (register or sign-extended immediate).
- out_valid  out  1  one-cycle pulse: result/flags updated.
- out  out  WIDTH  primary result.
- out_hi  out  WIDTH  mul high half / div remainder; 0 for other ops.
- carryFlag, zeroflag, signFlag, overflowFlag  out  1 each  status flags.

## Operation
- Accept on a rising edge with in_valid & in_ready; opcode, fcode, input1, input2 are sampled only then.
- States: IDLE, ITER. Single-cycle ops stay in IDLE. MUL/DIV go IDLE→ITER; after WIDTH iterations they return to IDLE.
- opcode 000 (R-type):
  - 0000 xor; 0001 and.
  - 0010 comp: out = −B (two's complement).
  - 0011 add: out = A+B.
  - 1010 sub: out = A−B.
  - 0100/0110 shll; 0101/0111 shrl; 1000/1001 shra.
  - 1011 mul (unsigned): {out_hi,out} = A×B.
  - 1100 divu: out = A/B, out_hi = A mod B.
- opcode 001 (I-type): 0000 compi (out = −B); 0001 addi (out = A+B).
- opcode 101 (branch test, fcode 0–2): out = 0; zeroflag = (A==0); signFlag = A[WIDTH−1]; carry and overflow 0.
- Any other opcode/fcode: accepted; out = out_hi = 0; all flags 0; out_valid still pulses.
- Shift amount is the full unsigned value of B. For B ≥ WIDTH, shll and shrl give 0 and shra gives all copies of A's sign bit.
- Flags (except opcode 101):
  - zeroflag = (out==0).
  - signFlag = out[WIDTH−1].
  - carryFlag: add/addi carry-out; sub = no-borrow (A ≥ B unsigned); 0 otherwise.
  - overflowFlag: add/addi/sub signed overflow; mul = (out_hi≠0); divu = (B==0); 0 otherwise.
- Divide by zero: out = all ones, out_hi = A, overflowFlag = 1. Latency is unchanged.
- MUL is shift-add and DIV is restoring, one bit per cycle. A $clog2(WIDTH)-bit counter counts WIDTH−1 down to 0. Operand, accumulator and remainder registers hold internal state.
- out, out_hi and the flags hold their values between out_valid pulses.

## Timing
- Reset: state IDLE; out, out_hi and all flags 0; out_valid 0; counter 0. in_ready is 0 during the rst cycle and 1 in the following cycle.
- Single-cycle ops: if accepted at edge E0, results are registered at E0 and out_valid is high for the cycle after E0. in_ready stays 1, so back-to-back issue gives one result per cycle.
- MUL/DIV: operands are captured at E0; in_ready drops after E0. Iterations occur at E1…E_WIDTH. The result is registered at E_WIDTH, and out_valid and in_ready are both high in the cycle after E_WIDTH, so latency is WIDTH cycles.
- in_valid while in_ready is low is ignored, not queued; the requester must hold it.
- rst asserted during ITER aborts the operation: no out_valid, outputs cleared, IDLE next cycle.
- A new accept in the same cycle as an out_valid pulse is legal.

## Test plan
- WIDTH=32, add 0xFFFFFFFF+0x1 → out 0, carry 1, zero 1, ov 0, sign 0, out_valid one cycle after accept; add 0x7FFFFFFF+0x1 → out 0x80000000, ov 1, sign 1, carry 0.
- sub 5−7 → out 0xFFFFFFFE, carry 0, sign 1; shra 0x80000000 by B=40 → out 0xFFFFFFFF; shll 0x1 by 32 → out 0, zero 1.
- mul 0x00010000×0x00010000 → out 0, out_hi 1, ov 1; out_valid exactly 32 cycles after accept; in_ready low for those 32 cycles; in_valid pulses meanwhile are ignored.
- divu 100/7 → out 14, out_hi 2, ov 0; divu 5/0 → out 0xFFFFFFFF, out_hi 5, ov 1, latency 32.
- rst asserted at iteration 10 of a mul → no out_valid; all outputs 0; in_ready high two cycles later; a following add 3+4 gives out 7.
- Ten back-to-back single-cycle ops (xor, and, comp, addi, branch-test A=0) → ten consecutive out_valid pulses with correct values; branch test gives zero 1, out 0; illegal opcode 111 gives out 0 and all flags 0.
